// File: rtl/qspi_arb_if.sv
// Request / grant / engine handshake bundle for the quad-SPI bus arbiter.
// master: the arbiter side. slave: the requesters plus the transaction engine.
interface qspi_arb_if #(
  parameter int ADDR_W = 24
) ();
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_done;
  logic              d_req;
  logic [ADDR_W-1:0] d_addr;
  logic              d_we;
  logic              d_sel;
  logic              d_gnt;
  logic              d_done;
  logic              d_err;
  logic              eng_start;
  logic [ADDR_W-1:0] eng_addr;
  logic              eng_we;
  logic              eng_sel;
  logic              eng_abort;
  logic              eng_done;

  modport master (
    input  if_req, if_addr, d_req, d_addr, d_we, d_sel, eng_done,
    output if_gnt, if_done, d_gnt, d_done, d_err,
           eng_start, eng_addr, eng_we, eng_sel, eng_abort
  );

  modport slave (
    output if_req, if_addr, d_req, d_addr, d_we, d_sel, eng_done,
    input  if_gnt, if_done, d_gnt, d_done, d_err,
           eng_start, eng_addr, eng_we, eng_sel, eng_abort
  );
endinterface

// File: rtl/qspi_bus_arbiter.sv
// Shared quad-SPI bus arbiter: instruction fetch vs. data port.
// The data port has priority. A streak counter hands the bus to ifetch once
// MAX_DATA_STREAK data grants have gone by while ifetch was waiting.
// A CS_GAP-cycle idle gap is forced between transactions.
// Optional feature: define QSPI_ARB_TIMEOUT_EN to add a BUSY watchdog that
// aborts the engine after TIMEOUT_CYCLES and completes the owner with d_err.
module qspi_bus_arbiter #(
  parameter int ADDR_W          = 24,
  parameter int MAX_DATA_STREAK = 4,
  parameter int CS_GAP          = 2,
  parameter int TIMEOUT_CYCLES  = 4096
) (
  input logic        clk,
  input logic        rst,
  qspi_arb_if.master bus
);
  localparam int SW = $clog2(MAX_DATA_STREAK + 1);
  localparam int GW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);
  localparam logic [GW-1:0] GAP_LAST   = GW'((CS_GAP > 0) ? CS_GAP - 1 : 0);

  typedef enum logic [1:0] {IDLE, START, BUSY, GAP} state_t;

  state_t            state, state_nxt;
  logic [GW-1:0]     gap_cnt, gap_nxt;
  logic [SW-1:0]     streak, streak_nxt;
  logic              owner_d, owner_nxt;        // 1 = data port owns the bus
  logic [ADDR_W-1:0] addr_q, addr_nxt;
  logic              we_q, we_nxt, sel_q, sel_nxt;
  logic              start_q, start_nxt;
  logic              if_gnt_q, if_gnt_nxt, d_gnt_q, d_gnt_nxt;
  logic              if_done_q, if_done_nxt, d_done_q, d_done_nxt;
  logic              err_q, err_nxt, abort_q, abort_nxt;
  logic              fin, fin_err;

`ifdef QSPI_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] tmo_cnt, tmo_nxt;

  // BUSY watchdog counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tmo_cnt <= '0;
    else     tmo_cnt <= tmo_nxt;
  end
`endif

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state, arbitration and next values of every registered output
  always_comb begin
    state_nxt   = state;
    gap_nxt     = gap_cnt;
    streak_nxt  = streak;
    owner_nxt   = owner_d;
    addr_nxt    = addr_q;
    we_nxt      = we_q;
    sel_nxt     = sel_q;
    start_nxt   = 1'b0;
    if_gnt_nxt  = if_gnt_q;
    d_gnt_nxt   = d_gnt_q;
    if_done_nxt = 1'b0;
    d_done_nxt  = 1'b0;
    err_nxt     = 1'b0;
    abort_nxt   = 1'b0;
    fin         = 1'b0;
    fin_err     = 1'b0;
`ifdef QSPI_ARB_TIMEOUT_EN
    tmo_nxt     = tmo_cnt;
`endif
    unique case (state)
      IDLE: begin
        if (bus.if_req && (!bus.d_req || streak == STREAK_MAX)) begin
          owner_nxt  = 1'b0;
          addr_nxt   = bus.if_addr;
          we_nxt     = 1'b0;
          sel_nxt    = 1'b0;
          if_gnt_nxt = 1'b1;
          streak_nxt = '0;
          start_nxt  = 1'b1;
          state_nxt  = START;
        end else if (bus.d_req) begin
          owner_nxt  = 1'b1;
          addr_nxt   = bus.d_addr;
          we_nxt     = bus.d_we;
          sel_nxt    = bus.d_sel;
          d_gnt_nxt  = 1'b1;
          // Only data grants that make ifetch wait count towards the streak
          if (!bus.if_req)              streak_nxt = '0;
          else if (streak != STREAK_MAX) streak_nxt = streak + 1'b1;
          start_nxt  = 1'b1;
          state_nxt  = START;
        end
      end
      START: begin
        // eng_done is deliberately not looked at here
        state_nxt = BUSY;
`ifdef QSPI_ARB_TIMEOUT_EN
        tmo_nxt   = '0;
`endif
      end
      BUSY: begin
        fin = bus.eng_done;
`ifdef QSPI_ARB_TIMEOUT_EN
        if (!bus.eng_done) begin
          if (tmo_cnt == TMO_LAST) begin
            fin       = 1'b1;
            fin_err   = 1'b1;
            abort_nxt = 1'b1;
          end else begin
            tmo_nxt = tmo_cnt + 1'b1;
          end
        end
`endif
        if (fin) begin
          if (owner_d) begin
            d_done_nxt = 1'b1;
            d_gnt_nxt  = 1'b0;
          end else begin
            if_done_nxt = 1'b1;
            if_gnt_nxt  = 1'b0;
          end
          err_nxt   = fin_err;
          gap_nxt   = '0;
          state_nxt = (CS_GAP == 0) ? IDLE : GAP;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) state_nxt = IDLE;
        else                     gap_nxt   = gap_cnt + 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output and bookkeeping registers; everything clears on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gap_cnt   <= '0;
      streak    <= '0;
      owner_d   <= 1'b0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      sel_q     <= 1'b0;
      start_q   <= 1'b0;
      if_gnt_q  <= 1'b0;
      d_gnt_q   <= 1'b0;
      if_done_q <= 1'b0;
      d_done_q  <= 1'b0;
      err_q     <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      gap_cnt   <= gap_nxt;
      streak    <= streak_nxt;
      owner_d   <= owner_nxt;
      addr_q    <= addr_nxt;
      we_q      <= we_nxt;
      sel_q     <= sel_nxt;
      start_q   <= start_nxt;
      if_gnt_q  <= if_gnt_nxt;
      d_gnt_q   <= d_gnt_nxt;
      if_done_q <= if_done_nxt;
      d_done_q  <= d_done_nxt;
      err_q     <= err_nxt;
      abort_q   <= abort_nxt;
    end
  end

  assign bus.eng_start = start_q;
  assign bus.eng_addr  = addr_q;
  assign bus.eng_we    = we_q;
  assign bus.eng_sel   = sel_q;
  assign bus.if_gnt    = if_gnt_q;
  assign bus.d_gnt     = d_gnt_q;
  assign bus.if_done   = if_done_q;
  assign bus.d_done    = d_done_q;
  assign bus.d_err     = err_q;
  assign bus.eng_abort = abort_q;
endmodule

// File: tb/tb_qspi_bus_arbiter.sv
// Directed bench for qspi_bus_arbiter (CS_GAP=2, MAX_DATA_STREAK=4, TIMEOUT_CYCLES=16).
module tb_qspi_bus_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  qspi_arb_if #(.ADDR_W(24)) bus ();

  qspi_bus_arbiter #(
    .ADDR_W(24), .MAX_DATA_STREAK(4), .CS_GAP(2), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".start"}, 32'(bus.eng_start), 0);
    chk({tag, ".if_gnt"}, 32'(bus.if_gnt), 0);
    chk({tag, ".d_gnt"}, 32'(bus.d_gnt), 0);
    chk({tag, ".if_done"}, 32'(bus.if_done), 0);
    chk({tag, ".d_done"}, 32'(bus.d_done), 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk_quiet(tag);
    chk({tag, ".addr"}, 32'(bus.eng_addr), 0);
    chk({tag, ".we"}, 32'(bus.eng_we), 0);
    chk({tag, ".sel"}, 32'(bus.eng_sel), 0);
    chk({tag, ".err"}, 32'(bus.d_err), 0);
    chk({tag, ".abort"}, 32'(bus.eng_abort), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "bench did not finish");
  end

  initial begin
    logic exp_owner [6];
    exp_owner = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    bus.if_req = 0; bus.if_addr = '0; bus.d_req = 0; bus.d_addr = '0;
    bus.d_we = 0; bus.d_sel = 0; bus.eng_done = 0;

    // ---- reset state
    tick(); tick();
    chk_all_zero("reset");
    rst = 0;
    tick();

    // ---- single ifetch, then gap before the next (ifetch) start
    bus.if_req = 1; bus.if_addr = 24'h000100;
    tick();
    chk("if1.start", 32'(bus.eng_start), 1);
    chk("if1.gnt", 32'(bus.if_gnt), 1);
    chk("if1.addr", 32'(bus.eng_addr), 32'h100);
    chk("if1.sel", 32'(bus.eng_sel), 0);
    chk("if1.we", 32'(bus.eng_we), 0);
    tick();
    chk("if1.start_once", 32'(bus.eng_start), 0);
    bus.eng_done = 1;
    tick();
    bus.eng_done = 0;
    chk("if1.done", 32'(bus.if_done), 1);
    chk("if1.gnt_clr", 32'(bus.if_gnt), 0);
    bus.if_addr = 24'h000104;
    tick();
    chk("gap1.start", 32'(bus.eng_start), 0);
    chk("gap1.done_pulse", 32'(bus.if_done), 0);
    tick();
    chk("gap2.start", 32'(bus.eng_start), 0);
    tick();
    chk("if2.start", 32'(bus.eng_start), 1);
    chk("if2.addr", 32'(bus.eng_addr), 32'h104);
    tick();
    bus.eng_done = 1;
    tick();
    bus.eng_done = 0;
    chk("if2.done", 32'(bus.if_done), 1);
    bus.if_req = 0;
    tick(); tick();

    // ---- simultaneous: data first, ifetch after data done + gap
    bus.if_req = 1; bus.if_addr = 24'h000200;
    bus.d_req = 1; bus.d_addr = 24'h010040; bus.d_we = 1; bus.d_sel = 1;
    tick();
    chk("sim.d_gnt", 32'(bus.d_gnt), 1);
    chk("sim.if_gnt", 32'(bus.if_gnt), 0);
    chk("sim.addr", 32'(bus.eng_addr), 32'h010040);
    chk("sim.sel", 32'(bus.eng_sel), 1);
    chk("sim.we", 32'(bus.eng_we), 1);
    tick();
    bus.eng_done = 1;
    tick();
    bus.eng_done = 0;
    chk("sim.d_done", 32'(bus.d_done), 1);
    chk("sim.if_done", 32'(bus.if_done), 0);
    bus.d_req = 0;
    tick(); tick(); tick();
    chk("sim.if_start", 32'(bus.eng_start), 1);
    chk("sim.if_gnt2", 32'(bus.if_gnt), 1);
    chk("sim.if_addr", 32'(bus.eng_addr), 32'h200);
    chk("sim.if_we", 32'(bus.eng_we), 0);
    tick();
    bus.eng_done = 1;
    tick();
    bus.eng_done = 0;
    chk("sim.if_done2", 32'(bus.if_done), 1);
    tick(); tick();

    // ---- starvation: both held; D D D D I D
    bus.d_req = 1; bus.d_we = 0; bus.d_sel = 0; bus.d_addr = 24'h000800;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("starve%0d.d_gnt", i), 32'(bus.d_gnt), 32'(exp_owner[i]));
      chk($sformatf("starve%0d.if_gnt", i), 32'(bus.if_gnt), 32'(!exp_owner[i]));
      tick();
      bus.eng_done = 1;
      tick();
      bus.eng_done = 0;
      chk($sformatf("starve%0d.d_done", i), 32'(bus.d_done), 32'(exp_owner[i]));
      tick(); tick();
    end
    bus.d_req = 0; bus.if_req = 0;

    // ---- stray eng_done in IDLE
    bus.eng_done = 1;
    tick();
    bus.eng_done = 0;
    chk_quiet("stray1");
    tick();
    chk_quiet("stray2");

    // ---- withdrawn d_req; eng_done during START ignored
    bus.d_req = 1; bus.d_addr = 24'h000055;
    tick();
    chk("wd.start", 32'(bus.eng_start), 1);
    chk("wd.gnt", 32'(bus.d_gnt), 1);
    bus.d_req = 0; bus.eng_done = 1;
    tick();
    bus.eng_done = 0;
    chk("wd.no_early_done", 32'(bus.d_done), 0);
    tick();
    chk("wd.still_gnt", 32'(bus.d_gnt), 1);
    bus.eng_done = 1;
    tick();
    bus.eng_done = 0;
    chk("wd.d_done", 32'(bus.d_done), 1);
    chk("wd.err", 32'(bus.d_err), 0);
    tick(); tick();

    // ---- reset mid-BUSY
    bus.d_req = 1; bus.d_addr = 24'hABCDEF; bus.d_we = 1; bus.d_sel = 1;
    tick(); tick();
    chk("rb.busy_gnt", 32'(bus.d_gnt), 1);
    rst = 1; bus.eng_done = 1;
    tick();
    chk_all_zero("rb.in_reset");
    rst = 0; bus.eng_done = 0; bus.d_req = 0;
    tick();
    chk_all_zero("rb.after");
    bus.if_req = 1; bus.if_addr = 24'h000300;
    tick();
    chk("rb.new_start", 32'(bus.eng_start), 1);
    chk("rb.new_addr", 32'(bus.eng_addr), 32'h300);
    tick();
    bus.eng_done = 1;
    tick();
    bus.eng_done = 0;
    chk("rb.new_done", 32'(bus.if_done), 1);
    bus.if_req = 0;
    tick(); tick();

`ifdef QSPI_ARB_TIMEOUT_EN
    // ---- watchdog: no eng_done for 16 BUSY cycles
    bus.d_req = 1; bus.d_addr = 24'h000777; bus.d_we = 0; bus.d_sel = 1;
    tick();
    chk("to.start", 32'(bus.eng_start), 1);
    for (int i = 0; i < 16; i++) begin
      tick();
      chk($sformatf("to.no_abort%0d", i), 32'(bus.eng_abort), 0);
    end
    tick();
    chk("to.abort", 32'(bus.eng_abort), 1);
    chk("to.d_done", 32'(bus.d_done), 1);
    chk("to.d_err", 32'(bus.d_err), 1);
    bus.d_req = 0;
    tick();
    chk("to.abort_pulse", 32'(bus.eng_abort), 0);
    tick();
    bus.d_req = 1; bus.d_sel = 0;
    tick();
    chk("to.next_start", 32'(bus.eng_start), 1);
    tick();
    bus.eng_done = 1;
    tick();
    bus.eng_done = 0;
    chk("to.next_done", 32'(bus.d_done), 1);
    chk("to.next_err", 32'(bus.d_err), 0);
    bus.d_req = 0;
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
